cordic_pipe: RTL

- Parametrised, fully pipelined CORDIC engine; next generation of the single-iteration stage.
- Per-sample mode selects rotation (sin/cos, polar-to-rectangular) or vectoring (magnitude/phase, rectangular-to-polar).
- Includes quadrant pre-rotation, an internal arctangent table, guard bits and a valid/ready handshake with full-pipeline stall.
- Sits between sample sources (oscillator/mixer front end) and downstream DSP in the audio datapath.

---
 rtl/cordic_pipe_if.sv | 33 +++
 rtl/cordic_pipe.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cordic_pipe_if.sv
// Sample stream interface for the pipelined CORDIC engine.
// The master side feeds input samples and accepts results; the slave side
// is the engine itself.
interface cordic_pipe_if #(
    parameter int WIDTH = 16,
    parameter int GUARD = 2
);

    logic                     in_valid;
    logic                     in_ready;
    logic                     in_mode;
    logic [WIDTH-1:0]         in_x;
    logic [WIDTH-1:0]         in_y;
    logic [WIDTH-1:0]         in_z;

    logic                     out_valid;
    logic                     out_ready;
    logic                     out_mode;
    logic [WIDTH+GUARD-1:0]   out_x;
    logic [WIDTH+GUARD-1:0]   out_y;
    logic [WIDTH-1:0]         out_z;

    modport master (
        output in_valid, in_mode, in_x, in_y, in_z, out_ready,
        input  in_ready, out_valid, out_mode, out_x, out_y, out_z
    );

    modport slave (
        input  in_valid, in_mode, in_x, in_y, in_z, out_ready,
        output in_ready, out_valid, out_mode, out_x, out_y, out_z
    );

endinterface

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC engine, rotation or vectoring selected per sample.
// One quadrant pre-rotation register followed by STAGES iteration registers.
// The whole pipe advances together whenever the output slot is free or is
// being consumed; bubbles are carried through, never collapsed.
// x/y results carry the CORDIC gain (~1.6468), no compensation is applied.
module cordic_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 14,
    parameter int GUARD  = 2
) (
    input  logic          clock,
    input  logic          reset,
    cordic_pipe_if.slave  bus
);

    localparam int W = WIDTH + GUARD;

    // atan(2^-i) scaled so that 2^32 is a full turn, rounded to nearest.
    function automatic logic [31:0] atan_raw(input logic [4:0] idx);
        logic [31:0] val;
        case (idx)
            5'd0:    val = 32'h2000_0000;
            5'd1:    val = 32'h12E4_051E;
            5'd2:    val = 32'h09FB_385B;
            5'd3:    val = 32'h0511_11D4;
            5'd4:    val = 32'h028B_0D43;
            5'd5:    val = 32'h0145_D7E1;
            5'd6:    val = 32'h00A2_F61E;
            5'd7:    val = 32'h0051_7C55;
            5'd8:    val = 32'h0028_BE53;
            5'd9:    val = 32'h0014_5F2F;
            5'd10:   val = 32'h000A_2F98;
            5'd11:   val = 32'h0005_17CC;
            5'd12:   val = 32'h0002_8BE6;
            5'd13:   val = 32'h0001_45F3;
            5'd14:   val = 32'h0000_A2FA;
            5'd15:   val = 32'h0000_517D;
            5'd16:   val = 32'h0000_28BE;
            5'd17:   val = 32'h0000_145F;
            5'd18:   val = 32'h0000_0A30;
            5'd19:   val = 32'h0000_0518;
            5'd20:   val = 32'h0000_028C;
            5'd21:   val = 32'h0000_0146;
            5'd22:   val = 32'h0000_00A3;
            5'd23:   val = 32'h0000_0051;
            5'd24:   val = 32'h0000_0029;
            5'd25:   val = 32'h0000_0014;
            5'd26:   val = 32'h0000_000A;
            5'd27:   val = 32'h0000_0005;
            5'd28:   val = 32'h0000_0003;
            5'd29:   val = 32'h0000_0001;
            5'd30:   val = 32'h0000_0001;
            default: val = 32'h0000_0000;
        endcase
        return val;
    endfunction

    // Rescale a table entry to a WIDTH-bit angle with round-to-nearest.
    function automatic logic [WIDTH-1:0] atan_entry(input logic [4:0] idx);
        logic [32:0] acc;
        acc = {1'b0, atan_raw(idx)};
        if (WIDTH < 32) begin
            acc = acc + (33'd1 << (31 - WIDTH));
            acc = acc >> (32 - WIDTH);
        end else begin
            acc = acc;
        end
        return WIDTH'(acc);
    endfunction

    // Pipeline state: index 0 is the pre-rotation register, index k the
    // result of iteration k-1, index STAGES drives the outputs.
    logic signed [W-1:0]  x_r [0:STAGES];
    logic signed [W-1:0]  y_r [0:STAGES];
    logic [WIDTH-1:0]     z_r [0:STAGES];
    logic [STAGES:0]      valid_r;
    logic [STAGES:0]      mode_r;

    logic                 ce_s;
    logic signed [W-1:0]  in_x_ext_s;
    logic signed [W-1:0]  in_y_ext_s;
    logic                 pre_flip_s;
    logic signed [W-1:0]  pre_x_s;
    logic signed [W-1:0]  pre_y_s;
    logic [WIDTH-1:0]     pre_z_s;

    logic signed [W-1:0]  x_nx_s [1:STAGES];
    logic signed [W-1:0]  y_nx_s [1:STAGES];
    logic [WIDTH-1:0]     z_nx_s [1:STAGES];
    logic [STAGES-1:0]    dir_s;

    // The pipe moves only when the output slot is empty or being taken.
    assign ce_s = ~valid_r[STAGES] | bus.out_ready;

    assign in_x_ext_s = {{GUARD{bus.in_x[WIDTH-1]}}, bus.in_x};
    assign in_y_ext_s = {{GUARD{bus.in_y[WIDTH-1]}}, bus.in_y};

    // Quadrant pre-rotation: fold the vector/angle into the CORDIC range by
    // negating x and y and adding pi to z.
    always_comb begin
        pre_flip_s = 1'b0;
        if (bus.in_mode) begin
            // vectoring: bring x into the right half plane (x = 0 stays)
            pre_flip_s = bus.in_x[WIDTH-1];
        end else begin
            // rotation: angle in quadrant 01 or 10 needs the pi fold
            pre_flip_s = bus.in_z[WIDTH-1] ^ bus.in_z[WIDTH-2];
        end

        if (pre_flip_s) begin
            pre_x_s = -in_x_ext_s;
            pre_y_s = -in_y_ext_s;
            pre_z_s = {~bus.in_z[WIDTH-1], bus.in_z[WIDTH-2:0]};
        end else begin
            pre_x_s = in_x_ext_s;
            pre_y_s = in_y_ext_s;
            pre_z_s = bus.in_z;
        end
    end

    // CORDIC micro-rotations: next value of every iteration register.
    always_comb begin
        dir_s = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (mode_r[i]) begin
                // vectoring: drive y towards zero
                dir_s[i] = y_r[i][W-1];
            end else begin
                // rotation: drive z towards zero
                dir_s[i] = ~z_r[i][WIDTH-1];
            end

            if (dir_s[i]) begin
                x_nx_s[i+1] = x_r[i] - (y_r[i] >>> i);
                y_nx_s[i+1] = y_r[i] + (x_r[i] >>> i);
                z_nx_s[i+1] = z_r[i] - atan_entry(5'(i));
            end else begin
                x_nx_s[i+1] = x_r[i] + (y_r[i] >>> i);
                y_nx_s[i+1] = y_r[i] - (x_r[i] >>> i);
                z_nx_s[i+1] = z_r[i] + atan_entry(5'(i));
            end
        end
    end

    // Pipeline registers: cleared on reset, shifted together when enabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= STAGES; k++) begin
                x_r[k] <= '0;
                y_r[k] <= '0;
                z_r[k] <= '0;
            end
            valid_r <= '0;
            mode_r  <= '0;
        end else if (ce_s) begin
            x_r[0]  <= pre_x_s;
            y_r[0]  <= pre_y_s;
            z_r[0]  <= pre_z_s;
            valid_r <= {valid_r[STAGES-1:0], bus.in_valid};
            mode_r  <= {mode_r[STAGES-1:0], bus.in_mode};
            for (int k = 1; k <= STAGES; k++) begin
                x_r[k] <= x_nx_s[k];
                y_r[k] <= y_nx_s[k];
                z_r[k] <= z_nx_s[k];
            end
        end
    end

    assign bus.in_ready  = ce_s;
    assign bus.out_valid = valid_r[STAGES];
    assign bus.out_mode  = mode_r[STAGES];
    assign bus.out_x     = x_r[STAGES];
    assign bus.out_y     = y_r[STAGES];
    assign bus.out_z     = z_r[STAGES];

endmodule
